// File: rtl/inst_queue.sv
// inst_queue: dual-ported in-order instruction queue between decoder and dispatch.
//
// Accepts up to two decoded entries per cycle into a circular buffer and shows
// the two oldest entries to dispatch, with slot 0 always the oldest. Entries are
// retired by the issue mask dispatch returns on invalid_en.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   flush       synchronous clear of head/tail/count
//   enq_valid   per-slot write request (slot 0 older)
//   enq_data    decoded instructions to write
//   enq_ready   at least two free entries (from registered count)
//   dqueue_en   per-slot read enable; disabled slots read as zero
//   invalid_en  issue mask; 11 pops two, 01 pops one, 10/00 pop none
//   deq_data    two oldest entries, zero where absent or not enabled
//   count       occupancy
//   empty/full  count == 0 / count == DEPTH
//
// Optional feature macro: INST_QUEUE_PERF_EN adds perf_full_stall,
// perf_dual_pop and perf_proto_err outputs.

package inst_queue_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } id_dispatch_t;
endpackage

module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [1:0]            enq_valid,
   input  id_dispatch_t [1:0]    enq_data,
   output logic                  enq_ready,
   input  logic [1:0]            dqueue_en,
   input  logic [1:0]            invalid_en,
   output id_dispatch_t [1:0]    deq_data,
   output logic [CNT_W-1:0]      count,
   output logic                  empty,
   output logic                  full
`ifdef INST_QUEUE_PERF_EN
   ,
   output logic [31:0]           perf_full_stall,
   output logic [31:0]           perf_dual_pop,
   output logic                  perf_proto_err
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   id_dispatch_t           mem_q [DEPTH];
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic [CNT_W-1:0]       nenq, npop_raw, npop;
   logic                   wr0_en, wr1_en;
   logic [PTR_W-1:0]       wr0_idx, wr1_idx;
   id_dispatch_t           wr0_data;

   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign enq_ready = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(2));

   always_comb begin
      nenq     = '0;
      wr0_en   = 1'b0;
      wr1_en   = 1'b0;
      wr0_idx  = tail_q;
      wr1_idx  = tail_q + PTR_W'(1);
      // A lone slot-1 request is compacted into the first free position.
      wr0_data = (enq_valid == 2'b10) ? enq_data[1] : enq_data[0];
      if (enq_ready && !flush) begin
         wr0_en = |enq_valid;
         wr1_en = &enq_valid;
         nenq   = (&enq_valid) ? CNT_W'(2) : ((|enq_valid) ? CNT_W'(1) : '0);
      end

      // 2'b10 is a protocol error and retires nothing.
      case (invalid_en)
         2'b11:   npop_raw = CNT_W'(2);
         2'b01:   npop_raw = CNT_W'(1);
         default: npop_raw = '0;
      endcase
      npop = (npop_raw > count_q) ? count_q : npop_raw;

      // Pop is judged on pre-edge count, so fresh entries are never retired
      // in the cycle they arrive.
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(npop);
         tail_d  = tail_q + PTR_W'(nenq);
         count_d = count_q + nenq - npop;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deq_data[i] = '0;
         if (dqueue_en[i] && (CNT_W'(i) < count_q))
            deq_data[i] = mem_q[head_q + PTR_W'(i)];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr0_en) mem_q[wr0_idx] <= wr0_data;
      if (wr1_en) mem_q[wr1_idx] <= enq_data[1];
   end

`ifdef INST_QUEUE_PERF_EN
   logic [31:0] perf_full_stall_q, perf_full_stall_d;
   logic [31:0] perf_dual_pop_q, perf_dual_pop_d;
   logic        perf_proto_err_q, perf_proto_err_d;

   always_comb begin
      perf_full_stall_d = perf_full_stall_q;
      perf_dual_pop_d   = perf_dual_pop_q;
      perf_proto_err_d  = perf_proto_err_q;
      if ((enq_valid != 2'b00) && !enq_ready)
         perf_full_stall_d = perf_full_stall_q + 32'd1;
      if (npop == CNT_W'(2))
         perf_dual_pop_d = perf_dual_pop_q + 32'd1;
      if ((invalid_en == 2'b10) && (count_q != '0))
         perf_proto_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_full_stall_q <= '0;
         perf_dual_pop_q   <= '0;
         perf_proto_err_q  <= 1'b0;
      end else begin
         perf_full_stall_q <= perf_full_stall_d;
         perf_dual_pop_q   <= perf_dual_pop_d;
         perf_proto_err_q  <= perf_proto_err_d;
      end
   end

   assign perf_full_stall = perf_full_stall_q;
   assign perf_dual_pop   = perf_dual_pop_q;
   assign perf_proto_err  = perf_proto_err_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
   import inst_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               flush = 1'b0;
   logic [1:0]         enq_valid = '0;
   id_dispatch_t [1:0] enq_data = '0;
   logic               enq_ready;
   logic [1:0]         dqueue_en = 2'b11;
   logic [1:0]         invalid_en = '0;
   id_dispatch_t [1:0] deq_data;
   logic [CNT_W-1:0]   count;
   logic               empty, full;
`ifdef INST_QUEUE_PERF_EN
   logic [31:0]        perf_full_stall, perf_dual_pop;
   logic               perf_proto_err;
`endif

   int checks = 0;
   int failures = 0;

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
      .dqueue_en(dqueue_en), .invalid_en(invalid_en), .deq_data(deq_data),
      .count(count), .empty(empty), .full(full)
`ifdef INST_QUEUE_PERF_EN
      , .perf_full_stall(perf_full_stall), .perf_dual_pop(perf_dual_pop),
      .perf_proto_err(perf_proto_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic [1:0]  ev;
      logic [31:0] p0, p1;
      logic [1:0]  dq, inv;
      int          cnt;
      logic [31:0] e0, e1;
      logic        rdy, ful, emp;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] J = 32'hDEAD_0000;

   function automatic logic [31:0] pa(input logic [31:0] base, input int n);
      return base + 32'(4 * n);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic addv(input logic fl, input logic [1:0] ev, input logic [31:0] p0, p1,
                       input logic [1:0] dq, inv, input int cnt,
                       input logic [31:0] e0, e1, input logic rdy, ful, emp);
      vec_t v;
      v.fl = fl; v.ev = ev; v.p0 = p0; v.p1 = p1; v.dq = dq; v.inv = inv;
      v.cnt = cnt; v.e0 = e0; v.e1 = e1; v.rdy = rdy; v.ful = ful; v.emp = emp;
      vecs.push_back(v);
   endtask

   // Drive at negedge, let one edge pass, sample 1ns later.
   task automatic step(input logic fl, input logic [1:0] ev, input logic [31:0] p0, p1,
                       input logic [1:0] dq, inv);
      flush = fl; enq_valid = ev; dqueue_en = dq; invalid_en = inv;
      enq_data[0].pc = p0; enq_data[0].inst = p0 ^ 32'hA5A5_0000;
      enq_data[1].pc = p1; enq_data[1].inst = p1 ^ 32'hA5A5_0000;
      @(posedge clk);
      #1;
      flush = 1'b0; enq_valid = '0; invalid_en = '0;
   endtask

   task automatic chk_state(input string nm, input int cnt, input logic [31:0] e0, e1,
                            input logic rdy, ful, emp);
      chk({nm, ".count"}, 32'(count), 32'(cnt));
      chk({nm, ".pc0"}, deq_data[0].pc, e0);
      chk({nm, ".pc1"}, deq_data[1].pc, e1);
      chk({nm, ".ready"}, 32'(enq_ready), 32'(rdy));
      chk({nm, ".full"}, 32'(full), 32'(ful));
      chk({nm, ".empty"}, 32'(empty), 32'(emp));
   endtask

   localparam logic [31:0] EB = 32'h1c00_0000;
   localparam logic [31:0] FB = 32'h1c10_0000;
   localparam logic [31:0] GB = 32'h1c20_0000;
   localparam logic [31:0] HB = 32'h1c30_0000;

   initial begin
      // fill / back-pressure / pops / compaction / protocol error / gating / wrap read
      addv(0, 2'b11, pa(EB,0), pa(EB,1), 2'b11, 2'b00, 2, pa(EB,0), pa(EB,1), 1, 0, 0);
      addv(0, 2'b11, pa(EB,2), pa(EB,3), 2'b11, 2'b00, 4, pa(EB,0), pa(EB,1), 1, 0, 0);
      addv(0, 2'b11, pa(EB,4), pa(EB,5), 2'b11, 2'b00, 6, pa(EB,0), pa(EB,1), 1, 0, 0);
      addv(0, 2'b11, pa(EB,6), pa(EB,7), 2'b11, 2'b00, 8, pa(EB,0), pa(EB,1), 0, 1, 0);
      addv(0, 2'b11, J, J,                2'b11, 2'b00, 8, pa(EB,0), pa(EB,1), 0, 1, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 6, pa(EB,2), pa(EB,3), 1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b01, 5, pa(EB,3), pa(EB,4), 1, 0, 0);
      addv(0, 2'b01, pa(EB,8), J,         2'b11, 2'b00, 6, pa(EB,3), pa(EB,4), 1, 0, 0);
      addv(0, 2'b10, J, pa(EB,9),         2'b11, 2'b00, 7, pa(EB,3), pa(EB,4), 0, 0, 0);
      addv(0, 2'b11, J, J,                2'b11, 2'b00, 7, pa(EB,3), pa(EB,4), 0, 0, 0);
      addv(0, 2'b01, J, J,                2'b11, 2'b00, 7, pa(EB,3), pa(EB,4), 0, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b10, 7, pa(EB,3), pa(EB,4), 0, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b01, 2'b11, 5, pa(EB,5), 0,        1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b00, 2'b00, 5, 0, 0,               1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 3, pa(EB,7), pa(EB,8), 1, 0, 0);
      addv(0, 2'b11, pa(EB,10), pa(EB,11),2'b11, 2'b11, 3, pa(EB,9), pa(EB,10),1, 0, 0);
      addv(0, 2'b11, pa(EB,12), pa(EB,13),2'b11, 2'b00, 5, pa(EB,9), pa(EB,10),1, 0, 0);
      // flush with same-cycle enqueue and pop
      addv(1, 2'b11, J, J,                2'b11, 2'b11, 0, 0, 0,               1, 0, 1);
      // steer to head=6,count=2,tail=0 then simultaneous enq+pop across wrap
      addv(0, 2'b11, pa(FB,0), pa(FB,1),  2'b11, 2'b00, 2, pa(FB,0), pa(FB,1), 1, 0, 0);
      addv(0, 2'b11, pa(FB,2), pa(FB,3),  2'b11, 2'b00, 4, pa(FB,0), pa(FB,1), 1, 0, 0);
      addv(0, 2'b11, pa(FB,4), pa(FB,5),  2'b11, 2'b00, 6, pa(FB,0), pa(FB,1), 1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 4, pa(FB,2), pa(FB,3), 1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 2, pa(FB,4), pa(FB,5), 1, 0, 0);
      addv(0, 2'b11, pa(FB,6), pa(FB,7),  2'b11, 2'b00, 4, pa(FB,4), pa(FB,5), 1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 2, pa(FB,6), pa(FB,7), 1, 0, 0);
      addv(0, 2'b11, pa(GB,0), pa(GB,1),  2'b11, 2'b11, 2, pa(GB,0), pa(GB,1), 1, 0, 0);
      // dual write with tail crossing index DEPTH-1
      addv(0, 2'b01, pa(GB,2), J,         2'b11, 2'b00, 3, pa(GB,0), pa(GB,1), 1, 0, 0);
      addv(0, 2'b11, pa(GB,3), pa(GB,4),  2'b11, 2'b00, 5, pa(GB,0), pa(GB,1), 1, 0, 0);
      addv(0, 2'b01, pa(GB,5), J,         2'b11, 2'b00, 6, pa(GB,0), pa(GB,1), 1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 4, pa(GB,2), pa(GB,3), 1, 0, 0);
      addv(0, 2'b01, pa(GB,6), J,         2'b11, 2'b00, 5, pa(GB,2), pa(GB,3), 1, 0, 0);
      addv(0, 2'b11, pa(GB,7), pa(GB,8),  2'b11, 2'b00, 7, pa(GB,2), pa(GB,3), 0, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 5, pa(GB,4), pa(GB,5), 1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 3, pa(GB,6), pa(GB,7), 1, 0, 0);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 1, pa(GB,8), 0,        1, 0, 0);
      // pop clamped to occupancy
      addv(0, 2'b00, 0, 0,                2'b11, 2'b11, 0, 0, 0,               1, 0, 1);
      addv(0, 2'b00, 0, 0,                2'b11, 2'b01, 0, 0, 0,               1, 0, 1);
      addv(0, 2'b10, J, pa(HB,0),         2'b11, 2'b00, 1, pa(HB,0), 0,        1, 0, 0);

      // reset held for three cycles
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_state("in_reset", 0, 0, 0, 1, 0, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_state("after_reset", 0, 0, 0, 1, 0, 1);
`ifdef INST_QUEUE_PERF_EN
      chk("perf_err_reset", 32'(perf_proto_err), 32'd0);
`endif

      foreach (vecs[i]) begin
         step(vecs[i].fl, vecs[i].ev, vecs[i].p0, vecs[i].p1, vecs[i].dq, vecs[i].inv);
         chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].e0, vecs[i].e1,
                   vecs[i].rdy, vecs[i].ful, vecs[i].emp);
         @(negedge clk);
      end

`ifdef INST_QUEUE_PERF_EN
      chk("perf_proto_err", 32'(perf_proto_err), 32'd1);
`endif

      // asynchronous reset mid-operation: clears before any edge
      step(0, 2'b11, pa(HB,1), pa(HB,2), 2'b11, 2'b00);
      chk("pre_rst.count", 32'(count), 32'd3);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk_state("async_rst", 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // ordered dual issue A,B,C,D
      step(0, 2'b11, 32'h0000_A000, 32'h0000_B000, 2'b11, 2'b00);
      @(negedge clk);
      step(0, 2'b11, 32'h0000_C000, 32'h0000_D000, 2'b11, 2'b00);
      chk_state("abcd_load", 4, 32'h0000_A000, 32'h0000_B000, 1, 0, 0);
      @(negedge clk);
      step(0, 2'b00, 0, 0, 2'b11, 2'b11);
      chk_state("abcd_pop2", 2, 32'h0000_C000, 32'h0000_D000, 1, 0, 0);
      @(negedge clk);
      step(0, 2'b00, 0, 0, 2'b11, 2'b01);
      chk_state("abcd_pop1", 1, 32'h0000_D000, 0, 1, 0, 0);
      @(negedge clk);

      // read gating at count 2
      step(0, 2'b01, 32'h0000_E000, 0, 2'b11, 2'b00);
      chk_state("gate_load", 2, 32'h0000_D000, 32'h0000_E000, 1, 0, 0);
      @(negedge clk);
      step(0, 2'b00, 0, 0, 2'b00, 2'b00);
      chk_state("gate_off", 2, 0, 0, 1, 0, 0);
      @(negedge clk);
      step(0, 2'b00, 0, 0, 2'b10, 2'b00);
      chk_state("gate_slot1", 2, 0, 32'h0000_E000, 1, 0, 0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
